// File: rtl/bus_pkg.sv
// Shared definitions for the bus arbiter.
//   state_t  : arbiter FSM state encoding
//   BUS_W    : default data width of the shared processor bus
//   pick_t   : round-robin search result (found flag + winner index)
//   rr_pick  : round-robin search over up to MAX_REQ request lines
package bus_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        TURN  = 2'd2
    } state_t;

    localparam int BUS_W   = 16;
    localparam int MAX_REQ = 8;

    typedef struct packed {
        logic       found;
        logic [2:0] winner;
    } pick_t;

    // Scan req starting at ptr, wrapping at nreq; the first asserted bit wins.
    // ptr < nreq and i < nreq, so one conditional subtract replaces a modulo.
    function automatic pick_t rr_pick(input logic [MAX_REQ-1:0] req,
                                      input logic [2:0]         ptr,
                                      input int unsigned        nreq);
        pick_t      p;
        logic [3:0] idx;
        p = '0;
        for (int unsigned i = 0; i < MAX_REQ; i++) begin
            idx = {1'b0, ptr} + 4'(i);
            if (idx >= 4'(nreq)) begin
                idx = idx - 4'(nreq);
            end
            if (i < nreq && !p.found && req[idx[2:0]]) begin
                p.found  = 1'b1;
                p.winner = idx[2:0];
            end
        end
        return p;
    endfunction

endpackage

// File: rtl/bus_arbiter_if.sv
// Handshake/bus bundle between the requesters and the arbiter.
//   req_i      : per-source level request
//   release_i  : per-source end-of-transfer strobe (owner's bit only honoured)
//   src_data_i : packed source data, source i at [i*DATA_W +: DATA_W]
//   gnt_o      : registered one-hot grant
//   owner_o    : index of current owner, valid while busy_o
//   busy_o     : any grant active
//   bus_o      : owner's data, zero when idle
//   preempt_o  : one-cycle pulse after a hold-limit preemption
// master = arbiter side, slave = requester side.
interface bus_arbiter_if #(
    parameter int NREQ   = 4,
    parameter int DATA_W = 16
);
    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [NREQ-1:0]        req_i;
    logic [NREQ-1:0]        release_i;
    logic [NREQ*DATA_W-1:0] src_data_i;
    logic [NREQ-1:0]        gnt_o;
    logic [PW-1:0]          owner_o;
    logic                   busy_o;
    logic [DATA_W-1:0]      bus_o;
    logic                   preempt_o;

    modport master (
        input  req_i, release_i, src_data_i,
        output gnt_o, owner_o, busy_o, bus_o, preempt_o
    );

    modport slave (
        output req_i, release_i, src_data_i,
        input  gnt_o, owner_o, busy_o, bus_o, preempt_o
    );

endinterface

// File: rtl/rr_picker.sv
// Combinational round-robin priority encoder.
//   req    : request vector
//   ptr    : index where the search starts
//   winner : first asserted index at or after ptr (wrapping)
//   found  : any request asserted
module rr_picker
    import bus_pkg::*;
#(
    parameter int NREQ = 4,
    localparam int PW  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic [NREQ-1:0] req,
    input  logic [PW-1:0]   ptr,
    output logic [PW-1:0]   winner,
    output logic            found
);

    pick_t pick;

    always_comb begin
        pick   = rr_pick(MAX_REQ'(req), 3'(ptr), NREQ);
        winner = PW'(pick.winner);
        found  = pick.found;
    end

endmodule

// File: rtl/bus_arbiter.sv
// Round-robin owner arbitration for the shared processor bus, with a hold
// limit against starvation and one dead cycle between owners.
//   clock  : system clock, rising edge
//   resetn : asynchronous active-low reset
//   bif    : bus_arbiter_if.master (requests, releases, source data in;
//            grant, owner, busy, bus, preempt out)
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | no owner; grant the round-robin winner at the next edge
// GRANT | owner drives the bus; watch release, request drop, hold limit
// TURN  | single dead cycle between owners; arbitrate as in IDLE
module bus_arbiter
    import bus_pkg::*;
#(
    parameter int NREQ     = 4,
    parameter int DATA_W   = BUS_W,
    parameter int MAX_HOLD = 8
) (
    input  logic          clock,
    input  logic          resetn,
    bus_arbiter_if.master bif
);

    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int HW = $clog2(MAX_HOLD + 1);

    state_t            state_q;
    logic [NREQ-1:0]   gnt_q;
    logic [PW-1:0]     owner_q;
    logic              busy_q;
    logic              preempt_q;
    logic [PW-1:0]     rr_ptr_q;
    logic [HW-1:0]     hold_cnt_q;

    logic [PW-1:0]     pick_winner;
    logic              pick_found;
    logic [NREQ-1:0]   gnt_d;
    logic [PW-1:0]     rr_ptr_d;
    logic              own_req;
    logic              own_rel;
    logic              others;
    logic              hold_at_max;
    logic [DATA_W-1:0] bus_d;

    rr_picker #(.NREQ(NREQ)) u_picker (
        .req    (bif.req_i),
        .ptr    (rr_ptr_q),
        .winner (pick_winner),
        .found  (pick_found)
    );

    // gnt_q is one-hot of the owner while in GRANT, so masking with it
    // isolates the owner's bits without decoding owner_q again.
    always_comb begin
        gnt_d       = NREQ'(1) << pick_winner;
        rr_ptr_d    = (pick_winner == PW'(NREQ - 1)) ? '0 : pick_winner + PW'(1);
        own_req     = |(bif.req_i & gnt_q);
        own_rel     = |(bif.release_i & gnt_q);
        others      = |(bif.req_i & ~gnt_q);
        hold_at_max = (hold_cnt_q == HW'(MAX_HOLD));
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q    <= IDLE;
            gnt_q      <= '0;
            owner_q    <= '0;
            busy_q     <= 1'b0;
            preempt_q  <= 1'b0;
            rr_ptr_q   <= '0;
            hold_cnt_q <= '0;
        end else begin
            preempt_q <= 1'b0;
            case (state_q)
                IDLE, TURN: begin
                    if (pick_found) begin
                        state_q    <= GRANT;
                        gnt_q      <= gnt_d;
                        owner_q    <= pick_winner;
                        busy_q     <= 1'b1;
                        rr_ptr_q   <= rr_ptr_d;
                        hold_cnt_q <= HW'(1);
                    end else begin
                        state_q <= IDLE;
                        gnt_q   <= '0;
                        busy_q  <= 1'b0;
                    end
                end
                GRANT: begin
                    // Release wins over the hold limit, so no preempt pulse then.
                    if (own_rel || !own_req) begin
                        state_q <= TURN;
                        gnt_q   <= '0;
                        busy_q  <= 1'b0;
                    end else if (hold_at_max && others) begin
                        state_q   <= TURN;
                        gnt_q     <= '0;
                        busy_q    <= 1'b0;
                        preempt_q <= 1'b1;
                    end else if (hold_at_max) begin
                        hold_cnt_q <= HW'(1);
                    end else begin
                        hold_cnt_q <= hold_cnt_q + HW'(1);
                    end
                end
                default: begin
                    state_q <= IDLE;
                    gnt_q   <= '0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    // Data path is combinational so source data changes reach the bus at once.
    always_comb begin
        bus_d = '0;
        if (busy_q) begin
            bus_d = bif.src_data_i[owner_q*DATA_W +: DATA_W];
        end
    end

    assign bif.gnt_o     = gnt_q;
    assign bif.owner_o   = owner_q;
    assign bif.busy_o    = busy_q;
    assign bif.bus_o     = bus_d;
    assign bif.preempt_o = preempt_q;

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed self-checking bench for bus_arbiter (NREQ=4, DATA_W=16, MAX_HOLD=8).
module tb_bus_arbiter;

    logic clock = 1'b0;
    logic resetn;
    int   n_assert = 0;
    int   n_fail   = 0;

    bus_arbiter_if #(.NREQ(4), .DATA_W(16)) bif ();

    bus_arbiter #(.NREQ(4), .DATA_W(16), .MAX_HOLD(8)) dut (
        .clock  (clock),
        .resetn (resetn),
        .bif    (bif)
    );

    always #5 clock = ~clock;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_assert++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    logic [15:0] src_val [4];
    int          order   [4];

    initial begin
        src_val[0] = 16'h1111;
        src_val[1] = 16'h2222;
        src_val[2] = 16'hBEEF;
        src_val[3] = 16'h3333;
        order[0] = 0; order[1] = 1; order[2] = 3; order[3] = 0;

        resetn             = 1'b0;
        bif.req_i          = '0;
        bif.release_i      = '0;
        bif.src_data_i     = {src_val[3], src_val[2], src_val[1], src_val[0]};

        // 1. reset and idle
        tick();
        tick();
        check_eq("rst_gnt",     32'(bif.gnt_o),     32'h0);
        check_eq("rst_busy",    32'(bif.busy_o),    32'h0);
        check_eq("rst_owner",   32'(bif.owner_o),   32'h0);
        check_eq("rst_bus",     32'(bif.bus_o),     32'h0);
        check_eq("rst_preempt", 32'(bif.preempt_o), 32'h0);
        resetn = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            check_eq("idle_gnt",  32'(bif.gnt_o),  32'h0);
            check_eq("idle_busy", 32'(bif.busy_o), 32'h0);
            check_eq("idle_bus",  32'(bif.bus_o),  32'h0);
        end

        // 2. single request, bus follows source data, release into TURN
        bif.req_i = 4'b0100;
        tick();
        check_eq("single_gnt",   32'(bif.gnt_o),   32'h4);
        check_eq("single_owner", 32'(bif.owner_o), 32'h2);
        check_eq("single_busy",  32'(bif.busy_o),  32'h1);
        check_eq("single_bus",   32'(bif.bus_o),   32'hBEEF);
        bif.src_data_i[32 +: 16] = 16'hCAFE;
        #1;
        check_eq("bus_follow", 32'(bif.bus_o), 32'hCAFE);
        bif.src_data_i[32 +: 16] = src_val[2];
        bif.release_i = 4'b0100;
        bif.req_i     = 4'b0000;
        tick();
        check_eq("turn_gnt",  32'(bif.gnt_o),  32'h0);
        check_eq("turn_busy", 32'(bif.busy_o), 32'h0);
        check_eq("turn_bus",  32'(bif.bus_o),  32'h0);
        bif.release_i = 4'b0000;
        tick();
        check_eq("back_idle_gnt", 32'(bif.gnt_o), 32'h0);
        bif.release_i = 4'b1111;
        tick();
        check_eq("stray_rel_idle", 32'(bif.gnt_o), 32'h0);
        bif.release_i = 4'b0000;

        // reset asserted mid-GRANT clears the grant before the next edge
        bif.req_i = 4'b0001;
        tick();
        check_eq("pre_rst_gnt", 32'(bif.gnt_o), 32'h1);
        #2;
        resetn = 1'b0;
        #1;
        check_eq("async_rst_gnt",  32'(bif.gnt_o),  32'h0);
        check_eq("async_rst_busy", 32'(bif.busy_o), 32'h0);
        check_eq("async_rst_bus",  32'(bif.bus_o),  32'h0);
        bif.req_i = 4'b0000;
        tick();
        resetn = 1'b1;

        // 3. round-robin handoff 0,1,3,0 with one dead cycle between owners
        bif.req_i = 4'b1011;
        tick();
        for (int k = 0; k < 4; k++) begin
            check_eq("rr_gnt_a",  32'(bif.gnt_o),   32'(4'b0001 << order[k]));
            check_eq("rr_owner",  32'(bif.owner_o), 32'(order[k]));
            check_eq("rr_bus",    32'(bif.bus_o),   32'(src_val[order[k]]));
            tick();
            check_eq("rr_gnt_b",  32'(bif.gnt_o),   32'(4'b0001 << order[k]));
            bif.release_i = 4'(4'b0001 << order[k]);
            tick();
            check_eq("rr_dead_gnt",  32'(bif.gnt_o),  32'h0);
            check_eq("rr_dead_busy", 32'(bif.busy_o), 32'h0);
            bif.release_i = 4'b0000;
            tick();
        end
        check_eq("rr_next_gnt", 32'(bif.gnt_o), 32'h2);
        bif.req_i = 4'b0000;
        tick();
        tick();
        check_eq("rr_idle_gnt", 32'(bif.gnt_o), 32'h0);

        // 4. hold limit with contention: 8 cycles, preempt in TURN, owner 1
        bif.req_i = 4'b0011;
        tick();
        for (int i = 0; i < 8; i++) begin
            check_eq("hold_gnt",     32'(bif.gnt_o),     32'h1);
            check_eq("hold_preempt", 32'(bif.preempt_o), 32'h0);
            tick();
        end
        check_eq("preempt_gnt",   32'(bif.gnt_o),     32'h0);
        check_eq("preempt_busy",  32'(bif.busy_o),    32'h0);
        check_eq("preempt_pulse", 32'(bif.preempt_o), 32'h1);
        tick();
        check_eq("after_pre_gnt",   32'(bif.gnt_o),     32'h2);
        check_eq("after_pre_owner", 32'(bif.owner_o),   32'h1);
        check_eq("after_pre_pulse", 32'(bif.preempt_o), 32'h0);
        check_eq("after_pre_bus",   32'(bif.bus_o),     32'h2222);
        bif.req_i = 4'b0000;
        tick();
        tick();

        // 5. hold limit without contention: grant kept, no preempt
        bif.req_i = 4'b0001;
        tick();
        for (int i = 0; i < 20; i++) begin
            check_eq("solo_gnt",     32'(bif.gnt_o),     32'h1);
            check_eq("solo_preempt", 32'(bif.preempt_o), 32'h0);
            tick();
        end
        bif.req_i = 4'b0000;
        tick();
        tick();

        // 6. release coinciding with hold limit; stray release from non-owner
        bif.req_i = 4'b0001;
        tick();
        for (int i = 1; i <= 8; i++) begin
            check_eq("sim_gnt", 32'(bif.gnt_o), 32'h1);
            if (i == 1) bif.req_i = 4'b0011;
            if (i == 8) bif.release_i = 4'b0001;
            tick();
        end
        check_eq("sim_turn_gnt",     32'(bif.gnt_o),     32'h0);
        check_eq("sim_turn_preempt", 32'(bif.preempt_o), 32'h0);
        bif.release_i = 4'b0000;
        tick();
        check_eq("sim_next_gnt",   32'(bif.gnt_o),   32'h2);
        check_eq("sim_next_owner", 32'(bif.owner_o), 32'h1);
        bif.release_i = 4'b1000;
        tick();
        check_eq("stray_rel_gnt",  32'(bif.gnt_o),  32'h2);
        check_eq("stray_rel_busy", 32'(bif.busy_o), 32'h1);
        bif.release_i = 4'b0000;
        bif.req_i     = 4'b0000;
        tick();
        tick();
        check_eq("final_gnt",  32'(bif.gnt_o),  32'h0);
        check_eq("final_busy", 32'(bif.busy_o), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
